// File: rtl/sound_pkg.sv
// Shared types and constants for the sound mixer: FSM state encoding,
// master volume width and the accumulator width helper.
package sound_pkg;

    localparam int MASTER_W = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_SCALE  = 3'd2,
        S_FILTER = 3'd3,
        S_DONE   = 3'd4
    } mix_state_e;

    // Width that holds the sum of num_ch unsigned lvl_w-bit levels.
    function automatic int sum_width(input int lvl_w, input int num_ch);
        return lvl_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/sound_dc_block.sv
// Single-side DC blocker: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT),
// saturated to signed OUT_W. Instantiated by sound_mixer under SOUND_MIXER_DC_BLOCK_EN.
module sound_dc_block
    import sound_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [OUT_W-1:0] x_raw,
    output logic [OUT_W-1:0] y
);

    localparam int EXT_W = OUT_W + 3;
    localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [OUT_W-1:0] x;
    logic signed [OUT_W-1:0] x_prev_q, x_prev_d;
    logic signed [OUT_W-1:0] y_prev_q, y_prev_d;
    logic signed [OUT_W-1:0] y_sat;
    logic signed [EXT_W-1:0] sum;

    always_comb begin
        // Subtracting 2^(OUT_W-1) from an MSB-clear sample is an MSB flip.
        x   = $signed({~x_raw[OUT_W-1], x_raw[OUT_W-2:0]});
        sum = EXT_W'(x) - EXT_W'(x_prev_q) + EXT_W'(y_prev_q) - EXT_W'(y_prev_q >>> DC_SHIFT);
        if (sum > Y_MAX) begin
            y_sat = Y_MAX[OUT_W-1:0];
        end else if (sum < Y_MIN) begin
            y_sat = Y_MIN[OUT_W-1:0];
        end else begin
            y_sat = sum[OUT_W-1:0];
        end
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        if (upd) begin
            x_prev_d = x;
            y_prev_d = y_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
        end else begin
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
        end
    end

    assign y = y_sat;

endmodule

// File: rtl/sound_mixer.sv
// sound_mixer: time-multiplexed NUM_CH-channel mixer with per-channel L/R routing
// and per-side master volume. Define SOUND_MIXER_DC_BLOCK_EN to add a DC-blocking pass.
module sound_mixer
    import sound_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int LVL_W    = 4,
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic [NUM_CH*LVL_W-1:0] ch_level,
    input  logic [NUM_CH-1:0]       ch_left_en,
    input  logic [NUM_CH-1:0]       ch_right_en,
    input  logic [MASTER_W-1:0]     master_left,
    input  logic [MASTER_W-1:0]     master_right,
    input  logic                    master_enable,
    output logic [OUT_W-1:0]        left,
    output logic [OUT_W-1:0]        right,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int SUM_W    = sum_width(LVL_W, NUM_CH);
    localparam int PROD_W   = SUM_W + MASTER_W;
    localparam int GAIN_W   = MASTER_W + 1;
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ALIGN_SH = OUT_W - 1 - PROD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_e state_q, state_d;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SUM_W-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [NUM_CH*LVL_W-1:0] snap_level_q, snap_level_d;
    logic [NUM_CH-1:0]       snap_len_q, snap_len_d, snap_ren_q, snap_ren_d;
    logic [MASTER_W-1:0]     snap_ml_q, snap_ml_d, snap_mr_q, snap_mr_d;
    logic [OUT_W-1:0]        left_q, left_d, right_q, right_d;
    logic                    overrun_q, overrun_d;

    logic [LVL_W-1:0]  cur_level;
    logic [GAIN_W-1:0] gain_l, gain_r;
    logic [PROD_W-1:0] prod_l, prod_r;
    logic [OUT_W-1:0]  aligned_l, aligned_r;
    logic              start;

    assign start     = (state_q == S_IDLE) && sample_tick && master_enable;
    assign cur_level = snap_level_q[int'(idx_q)*LVL_W +: LVL_W];
    assign gain_l    = GAIN_W'(snap_ml_q) + GAIN_W'(1);
    assign gain_r    = GAIN_W'(snap_mr_q) + GAIN_W'(1);
    assign prod_l    = PROD_W'(acc_l_q) * PROD_W'(gain_l);
    assign prod_r    = PROD_W'(acc_r_q) * PROD_W'(gain_r);
    // Left-align under a zero sign bit so the sample stays non-negative.
    assign aligned_l = OUT_W'(prod_l) << ALIGN_SH;
    assign aligned_r = OUT_W'(prod_r) << ALIGN_SH;

`ifdef SOUND_MIXER_DC_BLOCK_EN
    logic [OUT_W-1:0] raw_l_q, raw_l_d, raw_r_q, raw_r_d;
    logic [OUT_W-1:0] filt_l, filt_r;
    logic             hist_upd;

    assign hist_upd = (state_q == S_FILTER) && master_enable;

    sound_dc_block #(.OUT_W(OUT_W), .DC_SHIFT(DC_SHIFT)) u_dc_left (
        .clk(clk), .rst(rst), .upd(hist_upd), .x_raw(raw_l_q), .y(filt_l)
    );
    sound_dc_block #(.OUT_W(OUT_W), .DC_SHIFT(DC_SHIFT)) u_dc_right (
        .clk(clk), .rst(rst), .upd(hist_upd), .x_raw(raw_r_q), .y(filt_r)
    );

    always_comb begin
        raw_l_d = raw_l_q;
        raw_r_d = raw_r_q;
        if (state_q == S_SCALE) begin
            raw_l_d = aligned_l;
            raw_r_d = aligned_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_l_q <= '0;
            raw_r_q <= '0;
        end else begin
            raw_l_q <= raw_l_d;
            raw_r_q <= raw_r_d;
        end
    end
`else
    logic unused_dc_shift;
    assign unused_dc_shift = (DC_SHIFT != 0);
`endif

    // Next-state logic; a disabled sound unit always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        if (!master_enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (sample_tick) state_d = S_ACCUM;
                S_ACCUM:  if (idx_q == LAST_IDX) state_d = S_SCALE;
`ifdef SOUND_MIXER_DC_BLOCK_EN
                S_SCALE:  state_d = S_FILTER;
                S_FILTER: state_d = S_DONE;
`else
                S_SCALE:  state_d = S_DONE;
`endif
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d        = idx_q;
        acc_l_d      = acc_l_q;
        acc_r_d      = acc_r_q;
        snap_level_d = snap_level_q;
        snap_len_d   = snap_len_q;
        snap_ren_d   = snap_ren_q;
        snap_ml_d    = snap_ml_q;
        snap_mr_d    = snap_mr_q;
        left_d       = left_q;
        right_d      = right_q;
        overrun_d    = overrun_q | (sample_tick && busy);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_level_d = ch_level;
                    snap_len_d   = ch_left_en;
                    snap_ren_d   = ch_right_en;
                    snap_ml_d    = master_left;
                    snap_mr_d    = master_right;
                    acc_l_d      = '0;
                    acc_r_d      = '0;
                    idx_d        = '0;
                end
            end
            S_ACCUM: begin
                if (snap_len_q[idx_q]) acc_l_d = acc_l_q + SUM_W'(cur_level);
                if (snap_ren_q[idx_q]) acc_r_d = acc_r_q + SUM_W'(cur_level);
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            S_SCALE: begin
`ifdef SOUND_MIXER_DC_BLOCK_EN
                // Raw samples are captured for the filter pass instead.
`else
                left_d  = aligned_l;
                right_d = aligned_r;
`endif
            end
`ifdef SOUND_MIXER_DC_BLOCK_EN
            S_FILTER: begin
                left_d  = filt_l;
                right_d = filt_r;
            end
`endif
            default: ;
        endcase
        if (!master_enable) begin
            left_d  = '0;
            right_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            snap_level_q <= '0;
            snap_len_q   <= '0;
            snap_ren_q   <= '0;
            snap_ml_q    <= '0;
            snap_mr_q    <= '0;
            left_q       <= '0;
            right_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            snap_level_q <= snap_level_d;
            snap_len_q   <= snap_len_d;
            snap_ren_q   <= snap_ren_d;
            snap_ml_q    <= snap_ml_d;
            snap_mr_q    <= snap_mr_d;
            left_q       <= left_d;
            right_q      <= right_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign left    = left_q;
    assign right   = right_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed self-checking bench for sound_mixer in its default build
// (NUM_CH=4, LVL_W=4, OUT_W=16, no DC blocker).
module tb_sound_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] ch_level = '0;
    logic [3:0]  ch_left_en = '0;
    logic [3:0]  ch_right_en = '0;
    logic [2:0]  master_left = '0;
    logic [2:0]  master_right = '0;
    logic        master_enable = 1'b0;
    logic [15:0] left;
    logic [15:0] right;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_assert = 0;
    int n_fail   = 0;

    sound_mixer #(.NUM_CH(4), .LVL_W(4), .OUT_W(16), .DC_SHIFT(8)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_level(ch_level),
        .ch_left_en(ch_left_en), .ch_right_en(ch_right_en),
        .master_left(master_left), .master_right(master_right),
        .master_enable(master_enable), .left(left), .right(right),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a pass at the current negedge and checks its result. Returns at the
    // negedge after the out_valid cycle, so the next pass starts at minimum spacing.
    task automatic run_pass(input string tag, input logic [15:0] lvl, input logic [3:0] len,
                            input logic [3:0] ren, input logic [2:0] ml, input logic [2:0] mr,
                            input bit scramble, input logic [15:0] exp_l, input logic [15:0] exp_r);
        int cycles;
        ch_level      = lvl;
        ch_left_en    = len;
        ch_right_en   = ren;
        master_left   = ml;
        master_right  = mr;
        master_enable = 1'b1;
        sample_tick   = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        if (scramble) begin
            ch_level     = ~lvl;
            ch_left_en   = ~len;
            ch_right_en  = ~ren;
            master_left  = ~ml;
            master_right = ~mr;
        end
        cycles = 1;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, " latency"}, cycles, 6);
        chk({tag, " left"}, left, exp_l);
        chk({tag, " right"}, right, exp_r);
        chk({tag, " busy in valid cycle"}, busy, 1);
        @(negedge clk);
        chk({tag, " valid one cycle"}, out_valid, 0);
        chk({tag, " busy after"}, busy, 0);
        chk({tag, " left held"}, left, exp_l);
    endtask

    initial begin
        int seen;
        logic [15:0] cap_l;
        logic [15:0] cap_r;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset left", left, 0);
        chk("reset right", right, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full scale: 4*15*8 = 480 -> <<6 = 0x7800
        run_pass("full scale", 16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b0, 16'h7800, 16'h7800);
        // Masters 0: 60 -> 0x0F00
        run_pass("master 0", 16'hFFFF, 4'hF, 4'hF, 3'd0, 3'd0, 1'b0, 16'h0F00, 16'h0F00);
        // Routing: left=ch0 (5), right=ch3 (3)
        run_pass("routing", 16'h3005, 4'b0001, 4'b1000, 3'd0, 3'd0, 1'b0, 16'h0140, 16'h00C0);
        // Mixed: left 10*3=30 -> 0x0780, right (4+2)*6=36 -> 0x0900
        run_pass("mixed", 16'h1234, 4'b1111, 4'b0101, 3'd2, 3'd5, 1'b0, 16'h0780, 16'h0900);
        // Inputs scrambled right after the tick must not affect the result
        run_pass("snapshot", 16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b1, 16'h7800, 16'h7800);
        chk("no overrun at min spacing", overrun, 0);

        // Abort: drop master_enable in ACCUM
        ch_level = 16'hFFFF; ch_left_en = 4'hF; ch_right_en = 4'hF;
        master_left = 3'd7; master_right = 3'd7; master_enable = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        master_enable = 1'b0;
        @(negedge clk);
        chk("abort left", left, 0);
        chk("abort right", right, 0);
        chk("abort busy", busy, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort no valid", seen, 0);
        // Tick while disabled is ignored
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("disabled tick busy", busy, 0);
        chk("disabled tick overrun", overrun, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("disabled tick no valid", seen, 0);
        master_enable = 1'b1;
        @(negedge clk);

        // Overrun: second tick 3 clocks after the first, with new inputs
        ch_level = 16'h3005; ch_left_en = 4'b0001; ch_right_en = 4'b1000;
        master_left = 3'd0; master_right = 3'd0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ch_level = 16'hFFFF; ch_left_en = 4'hF; ch_right_en = 4'hF;
        master_left = 3'd7; master_right = 3'd7;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("overrun set", overrun, 1);
        seen = 0;
        cap_l = '0;
        cap_r = '0;
        repeat (14) begin
            if (out_valid) begin
                seen++;
                cap_l = left;
                cap_r = right;
            end
            @(negedge clk);
        end
        chk("overrun single valid", seen, 1);
        chk("overrun first left", cap_l, 16'h0140);
        chk("overrun first right", cap_r, 16'h00C0);
        run_pass("after overrun", 16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b0, 16'h7800, 16'h7800);
        chk("overrun sticky", overrun, 1);

        // Reset mid-pass
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst left", left, 0);
        chk("midrst right", right, 0);
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);
        run_pass("post reset", 16'h3005, 4'b0001, 4'b1000, 3'd0, 3'd0, 1'b0, 16'h0140, 16'h00C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_mixer.md
# sound_mixer

Parametrised, time-multiplexed mixer for the sound unit: takes NUM_CH unsigned channel levels and mixes them into registered left and right samples. Each channel has its own left/right routing enable, and each side has a master volume. Work starts on a sample tick: the block snapshots the levels, accumulates one channel per clock, applies the master volume as (level+1), and emits the result with a one-cycle valid strobe. It sits between the channel generators and the audio codec interface, replacing the fixed 4-channel combinational adder/multiplier mixer.

## Interface
- NUM_CH, 4, number of input channels (≥1)
- LVL_W, 4, bits per channel level
- OUT_W, 16, output sample width; must be ≥ LVL_W+$clog2(NUM_CH)+4
- DC_SHIFT, 8, DC-blocker pole shift; used only when SOUND_MIXER_DC_BLOCK_EN is defined

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse that starts a mix pass
- ch_level  in  NUM_CH*LVL_W  channel levels, unsigned; channel i is at [i*LVL_W +: LVL_W]
- ch_left_en  in  NUM_CH  route channel i to left
- ch_right_en  in  NUM_CH  route channel i to right
- master_left  in  3  left volume; gain is value+1
- master_right  in  3  right volume; gain is value+1
- master_enable  in  1  global sound enable (NR52 bit 7)
- left  out  OUT_W  left sample
- right  out  OUT_W  right sample
- out_valid  out  1  one-cycle pulse when left/right update
- busy  out  1  high while a pass is in progress
- overrun  out  1  sticky; set when sample_tick arrives while busy; cleared only by rst

## Operation
- States: IDLE → ACCUM → SCALE → (FILTER, macro only) → DONE → IDLE.
- **IDLE.** When sample_tick=1 and master_enable=1:
  - snapshot ch_level, ch_left_en, ch_right_en, master_left and master_right;
  - clear both accumulators, set idx=0, go to ACCUM.
- **ACCUM.** One channel per cycle:
  - add snap_level[idx] to acc_l if left_en[idx] is set, and to acc_r if right_en[idx] is set;
  - go to SCALE after idx = NUM_CH-1.
- **SCALE.** Compute prod = acc × (master+1), with SUM_W = LVL_W+$clog2(NUM_CH) and prod width SUM_W+3. Overflow is not possible.
- **DONE.**
  - Without the macro, output {1'b0, prod, zeros} left-aligned to OUT_W (unsigned, MSB zero).
  - Assert out_valid for one cycle, then go to IDLE.
- Inputs changing during a pass have no effect, because the snapshot is used throughout.
- sample_tick while busy: the tick is dropped, overrun is set, and the current pass continues.
- master_enable=0 in any state:
  - abort to IDLE on the next edge;
  - left and right go to 0 on that edge;
  - no out_valid.
- master_enable=0 in IDLE: sample_tick is ignored (overrun is not set).
- Simultaneous DONE and sample_tick: the tick is counted as overrun, so a new pass can only start from IDLE.

## Timing
- Reset values: left=0, right=0, out_valid=0, busy=0, overrun=0, state IDLE, idx=0, filter history=0.
- Latency from the sample_tick cycle to the out_valid cycle: NUM_CH+2 clocks, or NUM_CH+3 with the macro.
- busy is high from the cycle after the tick up to and including the out_valid cycle.
- Minimum tick spacing without overrun is therefore NUM_CH+3 clocks (NUM_CH+4 with the macro).
- left and right hold their value between out_valid pulses.
- rst mid-pass: everything returns to reset values on that edge.

## Configuration
- SOUND_MIXER_DC_BLOCK_EN defined:
  - adds a FILTER state with a per-side high-pass: y = x − x_prev + y_prev − (y_prev >>> DC_SHIFT);
  - x is the left-aligned unsigned sample reinterpreted as signed (x − 2^(OUT_W−1));
  - y saturates to signed OUT_W;
  - outputs are two's complement;
  - x_prev and y_prev update only on completed passes.
- Undefined: no filter logic, unsigned outputs, and DC_SHIFT is ignored.

## Structure
- Package sound_pkg holds:
  - the mixer state enum;
  - the function computing SUM_W from LVL_W and NUM_CH;
  - the master volume width constant (3).
- One sub-module: sound_dc_block (single-side filter, instantiated twice), present only under the macro.

## Test plan
All scenarios use defaults (NUM_CH=4, LVL_W=4, OUT_W=16) unless stated otherwise.
- **Full scale.** All levels 15, all routed both sides, masters 7, tick → out_valid 6 clocks later, left=right=0x7800.
- **Master 0 and routing.** Masters 0, same levels → left=right=0x0F00. Left_en=4'b0001, right_en=4'b1000, levels {3,0,0,5} for ch3..ch0, masters 0 → left=0x0140, right=0x00C0.
- **Overrun.** Second tick 3 clocks after the first → overrun=1, a single out_valid, the first pass's result unchanged. overrun stays 1 until rst.
- **Abort.** master_enable dropped in ACCUM → next edge left=right=0, busy=0, no out_valid. A tick while disabled is ignored.
- **Snapshot/reset.** Levels changed mid-pass → result uses the values snapshotted at the tick. rst asserted mid-pass → all outputs 0 next edge.
- **Macro on.** Constant full-scale input with DC_SHIFT=4 over repeated passes → |output| decays monotonically toward 0. No saturation flag on the first step.
